music_uart_rx: RTL

UART receiver for the music/tile subsystem: accepts 8N1 serial frames from the host (Python over AD2) on a single input pin, recovers the bytes, and buffers them in a small FIFO for the game/music control logic. It is the receive-side counterpart of the existing 8N1 transmitter, using the same baud derivation, so one `CLK_FREQ`/`BAUD_RATE` pair configures both directions. Framing errors and overflow are reported as sticky flags.

---
 rtl/music_uart_rx_pkg.sv | 28 ++
 rtl/music_uart_rx_if.sv | 24 ++
 rtl/music_uart_rx_fifo.sv | 79 +++++++
 rtl/music_uart_rx.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/music_uart_rx_pkg.sv
// Shared definitions for the 8N1 UART receive path: FSM states and baud derivation
// (the same derivation the transmitter uses, so one CLK_FREQ/BAUD_RATE pair serves both).
package music_uart_rx_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_RECOVER = 3'd4
  } rx_state_e;

  function automatic int baud_div(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic int half_div(input int clk_freq, input int baud_rate);
    return baud_div(clk_freq, baud_rate) / 2;
  endfunction

  // Counter width never collapses to zero, even for degenerate divisors.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/music_uart_rx_if.sv
// Serial-in / byte-out bundle of the UART receiver; the DUT takes the slave view,
// the host logic (or bench) takes the master view.
interface music_uart_rx_if;
  import music_uart_rx_pkg::*;

  logic                 rx;
  logic                 rd_en;
  logic                 err_clr;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 busy;
  logic                 frame_err;
  logic                 overflow;

  modport master (
    output rx, rd_en, err_clr,
    input  rx_data, rx_valid, busy, frame_err, overflow
  );

  modport slave (
    input  rx, rd_en, err_clr,
    output rx_data, rx_valid, busy, frame_err, overflow
  );
endinterface

// File: rtl/music_uart_rx_fifo.sv
// First-word-fall-through synchronous FIFO; a push into a full FIFO succeeds only
// when a pop frees a slot in the same cycle, otherwise it is dropped and flagged.
module music_uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             drop_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_s, empty_s, do_push_s, do_pop_s;

  assign full_s    = (count_q == CNT_FULL);
  assign empty_s   = (count_q == {CNT_W{1'b0}});
  assign do_pop_s  = pop_i && !empty_s;
  assign do_push_s = push_i && (!full_s || do_pop_s);
  assign drop_o    = push_i && full_s && !do_pop_s;
  assign valid_o   = !empty_s;
  assign data_o    = empty_s ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are only observable while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/music_uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling FSM, sticky error flags
// and a small FWFT receive FIFO.
module music_uart_rx #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  music_uart_rx_if.slave  bus
);
  import music_uart_rx_pkg::*;

  localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD_RATE);
  localparam int HALF     = half_div(CLK_FREQ, BAUD_RATE);
  localparam int CNT_W    = cnt_width(BAUD_DIV);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

  logic [1:0]           sync_q;
  logic                 rx_s;
  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overflow_q, overflow_d;
  logic                 push_s, ferr_set_s, drop_s;

  assign rx_s = sync_q[1];

  // Receive FSM next-state: sample points at half-bit then every full bit period.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    push_s     = 1'b0;
    ferr_set_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d     = CNT_ZERO;
        bit_idx_d = 3'd0;
        if (!rx_s) begin
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = CNT_ZERO;
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d              = CNT_ZERO;
          shreg_d[bit_idx_q] = rx_s;
          bit_idx_d          = bit_idx_q + 3'd1;
          state_d            = (bit_idx_q == 3'd7) ? ST_STOP : ST_DATA;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d      = CNT_ZERO;
          push_s     = rx_s;
          ferr_set_s = !rx_s;
          state_d    = rx_s ? ST_IDLE : ST_RECOVER;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_RECOVER: begin
        // A held-low line must not be mistaken for a fresh start bit.
        cnt_d = CNT_ZERO;
        if (rx_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RECOVER;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        cnt_d     = CNT_ZERO;
        bit_idx_d = 3'd0;
      end
    endcase
  end

  // Sticky flags: a new error event wins over a simultaneous clear.
  always_comb begin
    frame_err_d = frame_err_q;
    overflow_d  = overflow_q;
    if (ferr_set_s) begin
      frame_err_d = 1'b1;
    end else if (bus.err_clr) begin
      frame_err_d = 1'b0;
    end else begin
      frame_err_d = frame_err_q;
    end
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (bus.err_clr) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Synchronizer, FSM and flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q      <= 2'b11;
      state_q     <= ST_IDLE;
      cnt_q       <= CNT_ZERO;
      bit_idx_q   <= 3'd0;
      shreg_q     <= {DATA_BITS{1'b0}};
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], bus.rx};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end

  music_uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_s),
    .data_i  (shreg_d),
    .pop_i   (bus.rd_en),
    .data_o  (bus.rx_data),
    .valid_o (bus.rx_valid),
    .drop_o  (drop_s)
  );

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.frame_err = frame_err_q;
  assign bus.overflow  = overflow_q;

endmodule
